// File: rtl/tlul_mailbox_pkg.sv
// Mailbox register map, STATUS/CTRL bit positions, register-select enum and
// the captured-response record.
package tlul_mailbox_pkg;

  localparam logic [3:0] MboxDataOffset   = 4'h0;
  localparam logic [3:0] MboxStatusOffset = 4'h4;
  localparam logic [3:0] MboxCtrlOffset   = 4'h8;
  localparam logic [3:0] MboxRsvdOffset   = 4'hC;

  localparam int StEmptyBit    = 0;
  localparam int StFullBit     = 1;
  localparam int StOverflowBit = 2;
  localparam int StCountLsb    = 8;

  localparam int CtrlFlushBit = 0;
  localparam int CtrlIrqEnBit = 1;

  typedef enum logic [1:0] {
    SelData   = 2'd0,
    SelStatus = 2'd1,
    SelCtrl   = 2'd2,
    SelRsvd   = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic        get;
    logic        err;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
  } mbox_rsp_t;

  // Unaligned offsets fall into the reserved slot and therefore error out.
  function automatic reg_sel_e addr_to_sel(logic [3:0] off);
    case (off)
      MboxDataOffset:   return SelData;
      MboxStatusOffset: return SelStatus;
      MboxCtrlOffset:   return SelCtrl;
      default:          return SelRsvd;
    endcase
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: A/D channel structs, opcodes and a 7-bit
// integrity helper shared by the response integrity generator.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Hamming-style check bits: bit k covers positions whose index has bit k set,
  // bit 6 is overall parity.
  function automatic logic [6:0] intg7(logic [56:0] v);
    logic [6:0] p;
    p = '0;
    for (int j = 0; j < 57; j++) begin
      for (int k = 0; k < 6; k++) begin
        if (((j >> k) & 1) != 0) p[k] = p[k] ^ v[j];
      end
      p[6] = p[6] ^ v[j];
    end
    return p;
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Mailbox message FIFO: registered storage, wrapping pointers, occupancy count
// and a flush that overrides any concurrent push or pop.
module mailbox_fifo #(
  parameter int Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [31:0]            wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [31:0]            rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? 32'h0 : mem_q[rptr_q];

  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Fills the D-channel user integrity fields from the response command and data.
module tlul_rsp_intg_gen
  import tlul_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);

  logic unused_user;
  assign unused_user = ^tl_i.d_user;

  always_comb begin
    tl_o = tl_i;
    tl_o.d_user.rsp_intg  = intg7(57'({tl_i.d_opcode, tl_i.d_size, tl_i.d_error}));
    tl_o.d_user.data_intg = intg7(57'(tl_i.d_data));
  end

endmodule

// File: rtl/tlul_mailbox.sv
// TL-UL device mailbox: DATA/STATUS/CTRL registers in front of a message FIFO.
// Optional message-pending interrupt built only when MAILBOX_IRQ_EN is defined.
module tlul_mailbox
  import tlul_pkg::*;
  import tlul_mailbox_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  tl_h2d_t     tl_i,
  output tl_d2h_t     tl_o,
  output logic        msg_valid_o,
  output logic [31:0] msg_data_o,
  input  logic        msg_ready_i,
  output logic        irq_o
);

  localparam int CW = $clog2(Depth) + 1;

  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          push, pop, flush;
  logic          accept, is_get, is_put, addr_hi_ok;
  reg_sel_e      sel;
  logic          ovf_set, ovf_clr, irq_en_wr, acc_err;
  logic [31:0]   acc_rdata, status_word;
  logic          ovf_q, ovf_d, rsp_pending_q, rsp_pending_d;
  mbox_rsp_t     rsp_q, rsp_d;
  tl_d2h_t       rsp;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

  assign accept     = tl_i.a_valid && !rsp_pending_q;
  assign is_get     = (tl_i.a_opcode == Get);
  assign is_put     = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign addr_hi_ok = (tl_i.a_address[31:4] == '0);
  assign sel        = addr_hi_ok ? addr_to_sel(tl_i.a_address[3:0]) : SelRsvd;
  assign pop        = msg_valid_o && msg_ready_i;

  always_comb begin
    status_word = '0;
    status_word[StEmptyBit]        = fifo_empty;
    status_word[StFullBit]         = fifo_full;
    status_word[StOverflowBit]     = ovf_q;
    status_word[StCountLsb +: 8]   = 8'(fifo_count);
  end

  // Request decode: every side effect happens in the accept cycle.
  always_comb begin
    push      = 1'b0;
    flush     = 1'b0;
    ovf_set   = 1'b0;
    ovf_clr   = 1'b0;
    irq_en_wr = 1'b0;
    acc_err   = 1'b0;
    acc_rdata = '0;
    if (accept) begin
      if (!(is_get || is_put) || sel == SelRsvd) begin
        acc_err = 1'b1;
      end else if (is_get) begin
        if (sel == SelStatus) acc_rdata = status_word;
      end else begin
        case (sel)
          SelData: begin
            if (tl_i.a_mask != 4'hF) begin
              acc_err = 1'b1;
            end else if (fifo_full && !pop) begin
              acc_err = 1'b1;
              ovf_set = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          SelStatus: ovf_clr = tl_i.a_data[StOverflowBit];
          SelCtrl: begin
            flush     = tl_i.a_data[CtrlFlushBit];
            irq_en_wr = 1'b1;
          end
          default: acc_err = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    rsp_pending_d = rsp_pending_q ? !tl_i.d_ready : accept;
    rsp_d = rsp_q;
    if (accept) begin
      rsp_d.get    = is_get;
      rsp_d.err    = acc_err;
      rsp_d.size   = tl_i.a_size;
      rsp_d.source = tl_i.a_source;
      rsp_d.data   = acc_rdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q         <= 1'b0;
      rsp_pending_q <= 1'b0;
    end else begin
      ovf_q         <= ovf_d;
      rsp_pending_q <= rsp_pending_d;
    end
  end

  // Response payload only matters while rsp_pending_q is set.
  always_ff @(posedge clk_i) begin
    rsp_q <= rsp_d;
  end

  always_comb begin
    rsp          = '0;
    rsp.d_valid  = rsp_pending_q;
    rsp.d_opcode = rsp_q.get ? AccessAckData : AccessAck;
    rsp.d_size   = rsp_q.size;
    rsp.d_source = rsp_q.source;
    rsp.d_data   = rsp_q.data;
    rsp.d_error  = rsp_q.err;
    rsp.a_ready  = !rsp_pending_q;
  end

  tlul_rsp_intg_gen u_rsp_intg (
    .tl_i (rsp),
    .tl_o (tl_o)
  );

  mailbox_fifo #(.Depth(Depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (tl_i.a_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (msg_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign msg_valid_o = !fifo_empty;

`ifdef MAILBOX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_wr ? tl_i.a_data[CtrlIrqEnBit] : irq_en_q;
    irq_d    = irq_en_q && !fifo_empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_en_wr;
  assign unused_irq_en_wr = irq_en_wr;
  assign irq_o = 1'b0;
`endif

endmodule

// File: doc/tlul_mailbox.md
TLUL_MAILBOX -- requirements
Module: tlul_mailbox

Interface
REQ-001 Parameter Depth, default 8, FIFO entries; power of two, 2..64.
REQ-002 clk_i  input  1  system clock; all state on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 tl_i  input  tlul_pkg::tl_h2d_t  TL-UL device request from xbar_main.
REQ-005 tl_o  output  tlul_pkg::tl_d2h_t  TL-UL device response to xbar_main.
REQ-006 msg_valid_o  output  1  FIFO head valid toward consuming core.
REQ-007 msg_data_o  output  32  FIFO head word.
REQ-008 msg_ready_i  input  1  consumer accepts head when high with msg_valid_o.
REQ-009 irq_o  output  1  message-pending interrupt; tied 0 without MAILBOX_IRQ_EN.

Function
REQ-010 Register map (word offsets, addr[3:2]): 0x0 DATA (W), 0x4 STATUS (R/W1C), 0x8 CTRL (W), 0xC reserved.
REQ-011 DATA write with a_mask 4'hF and FIFO not full: push a_data; count+1.
REQ-012 DATA write when full: no push, STATUS.overflow set, d_error 1.
REQ-013 DATA write with a_mask != 4'hF: no push, d_error 1.
REQ-014 STATUS read: [0] empty, [1] full, [2] overflow (sticky), [15:8] count (zero-extended), rest 0.
REQ-015 STATUS write with data[2]=1 clears overflow; other bits ignored; no error.
REQ-016 CTRL write data[0]=1: flush FIFO (count 0, pointers 0) in accept cycle; data[1] written to irq_en.
REQ-017 Reads of DATA/CTRL return 0 without error; 0xC, addresses >= 0x10, or opcodes other than Get/PutFullData/PutPartialData: d_error 1, no side effect.
REQ-018 Single outstanding transaction: a_ready = !rsp_pending; request accepted when a_valid && a_ready.
REQ-019 Response d_valid asserted exactly one cycle after accept; held with stable fields until d_ready.
REQ-020 d_opcode AccessAckData for Get, AccessAck for Put; d_source, d_size echo request; d_sink 0.
REQ-021 Response integrity generated by tlul_rsp_intg_gen; request integrity not checked.
REQ-022 msg_valid_o = !empty; msg_data_o = head entry; pop when msg_valid_o && msg_ready_i.
REQ-023 No bypass: word pushed into empty FIFO appears on msg_valid_o the cycle after accept.
REQ-024 Push and pop same cycle: both take effect, count unchanged, including when full (push succeeds, no overflow).
REQ-025 Flush and pop same cycle: flush wins, count 0.
REQ-026 Pointers wrap modulo Depth; count width $clog2(Depth)+1, saturates never (guarded by full/empty).

Reset
REQ-027 On rst_i: count, pointers, overflow, irq_en, rsp_pending cleared; d_valid 0, a_ready 1, msg_valid_o 0, msg_data_o 0, irq_o 0.
REQ-028 Reset mid-transaction drops pending response and FIFO contents; no response issued after reset.
REQ-029 Storage array need not be reset; msg_data_o reads 0 whenever empty.

Configuration
REQ-030 Macro MAILBOX_IRQ_EN defined: irq_o registered, = irq_en && !empty, updates one cycle after count change.
REQ-031 MAILBOX_IRQ_EN undefined: irq_o constant 0, irq_en bit not stored, CTRL data[1] ignored.

Structure
REQ-032 Package tlul_mailbox_pkg: register offset constants, STATUS bit indices, reg-select enum.
REQ-033 One sub-module mailbox_fifo (storage, pointers, count, flush); TL decode and response in top.

Verification
REQ-034 Write 0xDEADBEEF to DATA, msg_ready_i 1 -> AccessAck, no error; msg_valid_o 1 for one cycle with 0xDEADBEEF.
REQ-035 msg_ready_i 0, 9 DATA writes (Depth 8) -> first 8 ok, 9th d_error 1; STATUS read = full,overflow,count 8 (0x0000_0806).
REQ-036 Full FIFO, DATA write while msg_ready_i 1 -> no error, count stays 8, order preserved.
REQ-037 CTRL write 0x1 with 5 entries -> next cycle msg_valid_o 0, STATUS 0x0000_0001.
REQ-038 Read 0xC, d_ready held low 3 cycles -> d_error 1 stable, a_ready 0 until d_ready.
REQ-039 With MAILBOX_IRQ_EN: CTRL 0x2, push one word -> irq_o 1; pop -> irq_o 0; rst_i mid-response -> d_valid 0 next edge.
